// File: rtl/tcdm_pkg.sv
// Shared constants for TCDM target-side blocks.
//   LfsrWidth/LfsrTapA/LfsrTapB : throttle LFSR geometry (x^9 + x^5 + 1)
//   CntWidth/CntMax             : statistics counter width and saturation value
//   sat_inc()                   : saturating +1 for statistics counters
package tcdm_pkg;

  localparam int unsigned LfsrWidth = 9;
  localparam int unsigned LfsrTapA  = 8;
  localparam int unsigned LfsrTapB  = 4;

  localparam int unsigned CntWidth  = 32;
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tcdm_lfsr.sv
// Fibonacci LFSR, shifts toward the MSB with the feedback bit entering at bit 0.
//   clk_i, rst_ni : clock, asynchronous active-low reset (state <= Seed)
//   en_i          : advance one step this cycle
//   state_o       : current LFSR state
module tcdm_lfsr #(
  parameter int unsigned        Width = 9,
  parameter logic [Width-1:0]   Seed  = '1,
  parameter int unsigned        TapA  = 8,
  parameter int unsigned        TapB  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] state_o
);

  // An all-zero state is a lock-up state for XOR feedback.
  if (Seed == '0) begin : g_seed_chk
    $error("tcdm_lfsr: Seed must be non-zero");
  end

  logic [Width-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[Width-2:0], lfsr_q[TapA] ^ lfsr_q[TapB]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= Seed;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM target endpoint: single-port, word-addressed, byte-maskable memory.
// Grants combinationally, returns read data one cycle after grant, optionally
// throttles grants with an LFSR, and exports saturating statistics counters.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_i / gnt_o        : request valid / combinational grant
//   add_i, wen_i, be_i   : word address, write enable, byte enables
//   wdata_i / rdata_o    : write data / registered read data
//   clr_cnt_i            : synchronous counter clear (wins over increment)
//   rd_cnt_o, wr_cnt_o   : granted reads / writes
//   stall_cnt_o          : cycles with req_i high and no grant
module tcdm_bank_responder
  import tcdm_pkg::*;
#(
  parameter int unsigned          AddWidth  = 4,
  parameter int unsigned          DataWidth = 32,
  localparam int unsigned         BeWidth   = DataWidth / 8,
  parameter int unsigned          StallMode = 0,
  parameter logic [LfsrWidth-1:0] LfsrSeed  = 9'h1FF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddWidth-1:0]  add_i,
  input  logic                 wen_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 clr_cnt_i,
  output logic [CntWidth-1:0]  rd_cnt_o,
  output logic [CntWidth-1:0]  wr_cnt_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);

  localparam int unsigned Depth = 2 ** AddWidth;

  if ((DataWidth % 8) != 0) begin : g_dw_chk
    $error("tcdm_bank_responder: DataWidth must be a multiple of 8");
  end

  // ---------------------------------------------------------------- grant
  logic [LfsrWidth-1:0] lfsr_q;
  logic                 stall, acc, rd_acc, wr_acc, stall_ev;

  // LFSR steps on every requesting cycle regardless of StallMode, so the
  // stall sequence depends only on request history.
  tcdm_lfsr #(
    .Width (LfsrWidth),
    .Seed  (LfsrSeed),
    .TapA  (LfsrTapA),
    .TapB  (LfsrTapB)
  ) i_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (req_i),
    .state_o (lfsr_q)
  );

  // Only bit 0 drives the throttle; the rest is LFSR state.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[LfsrWidth-1:1];

  assign stall    = (StallMode != 0) ? lfsr_q[0] : 1'b0;
  assign gnt_o    = req_i & ~stall;
  assign acc      = req_i & gnt_o;
  assign rd_acc   = acc & ~wen_i;
  assign wr_acc   = acc &  wen_i;
  assign stall_ev = req_i & ~gnt_o;

  // --------------------------------------------------------------- memory
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (be_i[b]) mem_q[add_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read data is held until the next accepted read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_q[add_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

  // ----------------------------------------------------------- statistics
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt_i) begin
      rd_cnt_d    = '0;
      wr_cnt_d    = '0;
      stall_cnt_d = '0;
    end else begin
      if (rd_acc)   rd_cnt_d    = sat_inc(rd_cnt_q);
      if (wr_acc)   wr_cnt_d    = sat_inc(wr_cnt_q);
      if (stall_ev) stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
